// File: rtl/acs_scheduler_if.sv
// Handshake and shared-ACS bus of the Viterbi ACS scheduler.
// The scheduler takes the slave view; its environment takes the master view.
interface acs_scheduler_if #(
  parameter int PM_W = 2,
  parameter int BM_W = 2
);
  logic [4*BM_W-1:0] i_bm;
  logic              i_bm_valid;
  logic              o_bm_ready;
  logic [BM_W-1:0]   o_acs_bm0;
  logic [BM_W-1:0]   o_acs_bm1;
  logic [PM_W-1:0]   o_acs_pm0;
  logic [PM_W-1:0]   o_acs_pm1;
  logic [PM_W-1:0]   i_acs_pm;
  logic [3:0]        o_dec;
  logic [1:0]        o_best_state;
  logic              o_dec_valid;
  logic              i_dec_ready;

  modport slave (
    input  i_bm, i_bm_valid, i_acs_pm, i_dec_ready,
    output o_bm_ready, o_acs_bm0, o_acs_bm1,
    output o_acs_pm0, o_acs_pm1,
    output o_dec, o_best_state, o_dec_valid
  );

  modport master (
    output i_bm, i_bm_valid, i_acs_pm, i_dec_ready,
    input  o_bm_ready, o_acs_bm0, o_acs_bm1,
    input  o_acs_pm0, o_acs_pm1,
    input  o_dec, o_best_state, o_dec_valid
  );
endinterface

// File: rtl/acs_scheduler.sv
// Time-multiplexed ACS scheduler for the K=3 rate-1/2 Viterbi decoder.
// Walks the 4 trellis states through one shared ACS and normalises metrics.
module acs_scheduler #(
  parameter int PM_W = 2,
  parameter int BM_W = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  acs_scheduler_if.slave bus
);
  localparam int SW = ((PM_W > BM_W) ? PM_W : BM_W) + 1;
  localparam logic [PM_W-1:0] PM_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACS, NORM, OUT} state_t;

  typedef struct packed {
    logic [BM_W-1:0] bm0;
    logic [BM_W-1:0] bm1;
    logic [PM_W-1:0] pm0;
    logic [PM_W-1:0] pm1;
  } acs_in_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [4*BM_W-1:0] bm_q;
  logic [PM_W-1:0]   pm [4];
  logic [PM_W-1:0]   new_pm [4];
  logic [3:0]        d;
  acs_in_t           acs_q;
  logic [3:0]        dec_q;
  logic [1:0]        best_q;
  logic              dec_valid_q;

  logic [PM_W-1:0]   m;
  logic [1:0]        best_c;
  logic              d_cur;

  function automatic logic [PM_W-1:0] sat(
    input logic [PM_W-1:0] p,
    input logic [BM_W-1:0] b
  );
    logic [SW-1:0] t;
    t = SW'(p) + SW'(b);
    return (t > SW'(PM_MAX)) ? PM_MAX : t[PM_W-1:0];
  endfunction

  // Predecessors {s0,0}/{s0,1}; codeword {b^q1^q0, b^q0} with b = s1.
  function automatic acs_in_t route(
    input logic [1:0]        s,
    input logic [4*BM_W-1:0] w
  );
    logic [1:0] p0, p1, c0, c1;
    acs_in_t    r;
    p0    = {s[0], 1'b0};
    p1    = {s[0], 1'b1};
    c0    = {s[1] ^ p0[1] ^ p0[0], s[1] ^ p0[0]};
    c1    = {s[1] ^ p1[1] ^ p1[0], s[1] ^ p1[0]};
    r.bm0 = w[c0*BM_W +: BM_W];
    r.bm1 = w[c1*BM_W +: BM_W];
    r.pm0 = pm[p0];
    r.pm1 = pm[p1];
    return r;
  endfunction

  assign d_cur = !(sat(acs_q.pm0, acs_q.bm0) <
                   sat(acs_q.pm1, acs_q.bm1));

  always_comb begin
    m      = new_pm[0];
    best_c = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (new_pm[i] < m) begin
        m      = new_pm[i];
        best_c = 2'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bm_q        <= '0;
      d           <= '0;
      acs_q       <= '0;
      dec_q       <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pm[i]     <= (i == 0) ? '0 : PM_MAX;
        new_pm[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_bm_valid) begin
            bm_q  <= bus.i_bm;
            cnt   <= '0;
            acs_q <= route(2'd0, bus.i_bm);
            state <= ACS;
          end
        end
        ACS: begin
          new_pm[cnt] <= bus.i_acs_pm;
          d[cnt]      <= d_cur;
          if (cnt == 2'd3) begin
            acs_q <= '0;
            state <= NORM;
          end else begin
            cnt   <= cnt + 2'd1;
            acs_q <= route(cnt + 2'd1, bm_q);
          end
        end
        NORM: begin
          for (int i = 0; i < 4; i++)
            pm[i] <= new_pm[i] - m;
          dec_q       <= d;
          best_q      <= best_c;
          dec_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.i_dec_ready) begin
            dec_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_bm_ready   = (state == IDLE);
  assign bus.o_acs_bm0    = acs_q.bm0;
  assign bus.o_acs_bm1    = acs_q.bm1;
  assign bus.o_acs_pm0    = acs_q.pm0;
  assign bus.o_acs_pm1    = acs_q.pm1;
  assign bus.o_dec        = dec_q;
  assign bus.o_best_state = best_q;
  assign bus.o_dec_valid  = dec_valid_q;
endmodule
